// File: rtl/axi_ddr_slave.sv
// ---------------------------------------------------------------------------
// axi_ddr_slave
//
// AXI4 responder for the core's 128-bit DDR master port. It is the
// simulation / block-RAM stand-in for the MIG DDR controller and connects
// directly to the M_AXI_* bus of the top level, with directions reversed.
//
// One transaction is handled at a time. If AW and AR are both valid in IDLE,
// the write is taken first. Bursts are always treated as INCR. The word index
// is ADDR[ADDR_W+3:4] and wraps modulo 2**ADDR_W. AxSIZE is not decoded.
// Write bursts end on beat AWLEN+1 (WLAST is ignored). Reads deliver one beat
// every two cycles: an RFETCH cycle addresses the RAM, then an RDATA cycle
// presents the registered read data.
//
// Optional feature (macro AXI_DDR_SLAVE_RANGE_CHECK_EN):
//   If defined, a transaction whose start byte address is at or above
//   16*2**ADDR_W is out of range. Out-of-range writes accept every beat,
//   write nothing, and answer SLVERR. Out-of-range reads return zero data
//   with SLVERR on every beat. If undefined, upper address bits alias and
//   every response is OKAY.
//
// Parameters:
//   ADDR_W : word-index width; store depth is 2**ADDR_W x 128 bits (ADDR_W<=22)
//   DATA_W : beat width, fixed at 128
//
// Ports:
//   clk, rst                   : clock, asynchronous active-high reset
//   S_AXI_AW*                  : write address channel (ADDR, LEN, BURST, VALID/READY)
//   S_AXI_W*                   : write data channel (DATA, STRB, LAST, VALID/READY)
//   S_AXI_B*                   : write response channel (RESP, VALID/READY)
//   S_AXI_AR*                  : read address channel (ADDR, LEN, BURST, VALID/READY)
//   S_AXI_R*                   : read data channel (DATA, RESP, LAST, VALID/READY)
// ---------------------------------------------------------------------------
module axi_ddr_slave #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [26:0]         S_AXI_AWADDR,
    input  logic [7:0]          S_AXI_AWLEN,
    input  logic [1:0]          S_AXI_AWBURST,
    input  logic                S_AXI_AWVALID,
    output logic                S_AXI_AWREADY,
    input  logic [DATA_W-1:0]   S_AXI_WDATA,
    input  logic [DATA_W/8-1:0] S_AXI_WSTRB,
    input  logic                S_AXI_WLAST,
    input  logic                S_AXI_WVALID,
    output logic                S_AXI_WREADY,
    output logic [1:0]          S_AXI_BRESP,
    output logic                S_AXI_BVALID,
    input  logic                S_AXI_BREADY,
    input  logic [26:0]         S_AXI_ARADDR,
    input  logic [7:0]          S_AXI_ARLEN,
    input  logic [1:0]          S_AXI_ARBURST,
    input  logic                S_AXI_ARVALID,
    output logic                S_AXI_ARREADY,
    output logic [DATA_W-1:0]   S_AXI_RDATA,
    output logic [1:0]          S_AXI_RRESP,
    output logic                S_AXI_RLAST,
    output logic                S_AXI_RVALID,
    input  logic                S_AXI_RREADY
);

    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_WRESP,
        ST_RFETCH,
        ST_RDATA
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [7:0]          len_q, len_d;
    logic                oor_q, oor_d;
    logic                bvalid_q, bvalid_d;
    logic [1:0]          bresp_q, bresp_d;
    logic                rvalid_q, rvalid_d;
    logic                rlast_q, rlast_d;
    logic [1:0]          rresp_q, rresp_d;
    // Selects the RAM output onto RDATA; cleared by reset so RDATA reads 0,
    // and cleared for out-of-range reads so they return zero data.
    logic                rdata_sel_q, rdata_sel_d;

    logic                aw_oor;
    logic                ar_oor;
    logic                wr_en;
    logic                last_beat;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   ram_dout;

`ifdef AXI_DDR_SLAVE_RANGE_CHECK_EN
    assign aw_oor = |S_AXI_AWADDR[26:ADDR_W+4];
    assign ar_oor = |S_AXI_ARADDR[26:ADDR_W+4];

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWADDR[3:0], S_AXI_ARADDR[3:0],
                         S_AXI_AWBURST, S_AXI_ARBURST, S_AXI_WLAST};
`else
    assign aw_oor = 1'b0;
    assign ar_oor = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWADDR[3:0], S_AXI_ARADDR[3:0],
                         S_AXI_AWADDR[26:ADDR_W+4], S_AXI_ARADDR[26:ADDR_W+4],
                         S_AXI_AWBURST, S_AXI_ARBURST, S_AXI_WLAST};
`endif

    // Ready decode straight from state; AR yields to a simultaneous AW.
    assign S_AXI_AWREADY = (state_q == ST_IDLE);
    assign S_AXI_ARREADY = (state_q == ST_IDLE) && !S_AXI_AWVALID;
    assign S_AXI_WREADY  = (state_q == ST_WDATA);

    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RLAST   = rlast_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_sel_q ? ram_dout : '0;

    assign last_beat = (cnt_q == len_q);
    assign wr_en     = (state_q == ST_WDATA) && S_AXI_WVALID && !oor_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        oor_d       = oor_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        rvalid_d    = rvalid_q;
        rlast_d     = rlast_q;
        rresp_d     = rresp_q;
        rdata_sel_d = rdata_sel_q;

        case (state_q)
            ST_IDLE: begin
                if (S_AXI_AWVALID) begin
                    idx_d   = S_AXI_AWADDR[ADDR_W+3:4];
                    len_d   = S_AXI_AWLEN;
                    cnt_d   = 8'd0;
                    oor_d   = aw_oor;
                    state_d = ST_WDATA;
                end else if (S_AXI_ARVALID) begin
                    idx_d   = S_AXI_ARADDR[ADDR_W+3:4];
                    len_d   = S_AXI_ARLEN;
                    cnt_d   = 8'd0;
                    oor_d   = ar_oor;
                    state_d = ST_RFETCH;
                end
            end

            ST_WDATA: begin
                if (S_AXI_WVALID) begin
                    idx_d = idx_q + 1'b1;
                    if (last_beat) begin
                        // Counter is not advanced on the final beat so a
                        // 256-beat burst never rolls the 8-bit count over.
                        bvalid_d = 1'b1;
                        bresp_d  = oor_q ? RESP_SLVERR : RESP_OKAY;
                        state_d  = ST_WRESP;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end

            ST_WRESP: begin
                if (S_AXI_BREADY) begin
                    bvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end

            ST_RFETCH: begin
                // RAM is addressed this cycle; its registered output is
                // valid together with RVALID on the next cycle.
                rvalid_d    = 1'b1;
                rlast_d     = last_beat;
                rresp_d     = oor_q ? RESP_SLVERR : RESP_OKAY;
                rdata_sel_d = !oor_q;
                state_d     = ST_RDATA;
            end

            ST_RDATA: begin
                if (S_AXI_RREADY) begin
                    rvalid_d = 1'b0;
                    if (rlast_q) begin
                        rlast_d = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        cnt_d   = cnt_q + 8'd1;
                        state_d = ST_RFETCH;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            cnt_q       <= 8'd0;
            len_q       <= 8'd0;
            oor_q       <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= 2'b00;
            rvalid_q    <= 1'b0;
            rlast_q     <= 1'b0;
            rresp_q     <= 2'b00;
            rdata_sel_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            oor_q       <= oor_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            rvalid_q    <= rvalid_d;
            rlast_q     <= rlast_d;
            rresp_q     <= rresp_d;
            rdata_sel_q <= rdata_sel_d;
        end
    end

    // Backing store: byte-enabled write port and registered read port.
    // Read data only updates in RFETCH, so it stays stable while RDATA stalls.
    always_ff @(posedge clk) begin
        for (int b = 0; b < STRB_W; b++) begin
            if (wr_en && S_AXI_WSTRB[b]) begin
                mem[idx_q][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
            end
        end
        if (state_q == ST_RFETCH) begin
            ram_dout <= mem[idx_q];
        end
    end

endmodule

// File: tb/tb_axi_ddr_slave.sv
module tb_axi_ddr_slave;

    localparam int TB_ADDR_W = 12;

    logic         clk = 1'b0;
    logic         rst;
    logic [26:0]  awaddr;
    logic [7:0]   awlen;
    logic [1:0]   awburst;
    logic         awvalid;
    logic         awready;
    logic [127:0] wdata;
    logic [15:0]  wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [26:0]  araddr;
    logic [7:0]   arlen;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready;
    logic [127:0] rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;

    int checks = 0;
    int errors = 0;

    logic [127:0] beat_data [256];

    always #5 clk = ~clk;

    axi_ddr_slave #(.ADDR_W(TB_ADDR_W), .DATA_W(128)) dut (
        .clk           (clk),
        .rst           (rst),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWLEN   (awlen),
        .S_AXI_AWBURST (awburst),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WLAST   (wlast),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARLEN   (arlen),
        .S_AXI_ARBURST (arburst),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RLAST   (rlast),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle 1 time unit past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write burst using beat_data[0..len]; checks BRESP.
    task automatic axi_write(input logic [26:0] addr, input int len,
                             input logic [15:0] strb, input logic [1:0] exp_bresp);
        int t;
        awaddr  = addr;
        awlen   = 8'(len);
        awburst = 2'b01;
        awvalid = 1'b1;
        t = 0;
        while (!awready && t < 100) begin tick(); t++; end
        if (t >= 100) check("aw_timeout", 128'(t), 128'd0);
        tick();
        awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            wdata  = beat_data[i];
            wstrb  = strb;
            wlast  = (i == len);
            wvalid = 1'b1;
            t = 0;
            while (!wready && t < 100) begin tick(); t++; end
            if (t >= 100) check("w_timeout", 128'(t), 128'd0);
            tick();
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        bready = 1'b1;
        t = 0;
        while (!bvalid && t < 100) begin tick(); t++; end
        check("bvalid", 128'(bvalid), 128'd1);
        check("bresp", 128'(bresp), 128'(exp_bresp));
        tick();
        bready = 1'b0;
        check("bvalid_drop", 128'(bvalid), 128'd0);
        $display("WRITE addr=%h len=%0d strb=%h bresp=%0d", addr, len, strb, bresp);
    endtask

    // Read burst checked against beat_data[0..len]. Odd beats stall one cycle
    // with RREADY low when stall_odd is set. If abort_beat is reached, reset is
    // pulsed while that beat is valid and the task returns.
    task automatic axi_read(input logic [26:0] addr, input int len, input bit stall_odd,
                            input logic [1:0] exp_rresp, input int abort_beat);
        int t;
        araddr  = addr;
        arlen   = 8'(len);
        arburst = 2'b01;
        arvalid = 1'b1;
        rready  = 1'b0;
        t = 0;
        while (!arready && t < 100) begin tick(); t++; end
        if (t >= 100) check("ar_timeout", 128'(t), 128'd0);
        tick();
        arvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            t = 0;
            while (!rvalid && t < 100) begin tick(); t++; end
            // RVALID must be up one edge after the AR (or previous R)
            // handshake edge: two cycles after the handshake cycle.
            check("r_latency", 128'(t), 128'd1);
            if (i == abort_beat) begin
                rst = 1'b1;
                #1;
                check("rvalid_async_rst", 128'(rvalid), 128'd0);
                check("rlast_async_rst", 128'(rlast), 128'd0);
                tick();
                tick();
                rst = 1'b0;
                #1;
                check("awready_after_rst", 128'(awready), 128'd1);
                $display("READ addr=%h aborted by reset at beat %0d", addr, i);
                return;
            end
            if (stall_odd && (i % 2 == 1)) begin
                tick();
                check("rvalid_stall", 128'(rvalid), 128'd1);
                check("rdata_stall", rdata, beat_data[i]);
                check("rlast_stall", 128'(rlast), 128'(i == len));
            end
            rready = 1'b1;
            check("rdata", rdata, beat_data[i]);
            check("rlast", 128'(rlast), 128'(i == len));
            check("rresp", 128'(rresp), 128'(exp_rresp));
            tick();
            rready = 1'b0;
        end
        check("rvalid_drop", 128'(rvalid), 128'd0);
        $display("READ addr=%h len=%0d rresp=%0d", addr, len, exp_rresp);
    endtask

    initial begin
        rst     = 1'b1;
        awaddr  = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
        wdata   = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        araddr  = '0; arlen = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_bvalid", 128'(bvalid), 128'd0);
        check("rst_rvalid", 128'(rvalid), 128'd0);
        check("rst_rlast", 128'(rlast), 128'd0);
        check("rst_rdata", rdata, 128'd0);
        check("rst_bresp", 128'(bresp), 128'd0);
        check("rst_rresp", 128'(rresp), 128'd0);
        check("rst_awready", 128'(awready), 128'd1);
        check("rst_arready", 128'(arready), 128'd1);
        check("rst_wready", 128'(wready), 128'd0);
        $display("RESET done");

        // Single write then read
        beat_data[0] = 128'h0123456789ABCDEF_0123456789ABCDEF;
        axi_write(27'h40, 0, 16'hFFFF, 2'b00);
        axi_read(27'h40, 0, 1'b0, 2'b00, -1);

        // Strobed write: only the low four bytes are cleared
        beat_data[0] = {128{1'b1}};
        axi_write(27'h50, 0, 16'hFFFF, 2'b00);
        beat_data[0] = 128'd0;
        axi_write(27'h50, 0, 16'h000F, 2'b00);
        beat_data[0] = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_00000000;
        axi_read(27'h50, 0, 1'b0, 2'b00, -1);

        // 4-beat burst, read with RREADY stalls on odd beats
        for (int i = 0; i < 4; i++) beat_data[i] = 128'(8'hA0 + i);
        axi_write(27'h100, 3, 16'hFFFF, 2'b00);
        axi_read(27'h100, 3, 1'b1, 2'b00, -1);

        // Simultaneous AW and AR: write wins, read is served afterwards
        beat_data[0] = 128'h5A5A_0000_1111_2222_3333_4444_5555_6666;
        awaddr  = 27'h200;
        awlen   = 8'd0;
        awvalid = 1'b1;
        araddr  = 27'h200;
        arlen   = 8'd0;
        arvalid = 1'b1;
        #1;
        check("simul_awready", 128'(awready), 128'd1);
        check("simul_arready", 128'(arready), 128'd0);
        axi_write(27'h200, 0, 16'hFFFF, 2'b00);
        check("simul_arready_after_b", 128'(arready), 128'd1);
        axi_read(27'h200, 0, 1'b0, 2'b00, -1);

        // Reset during the 3rd beat of an 8-beat read, then a normal transaction
        for (int i = 0; i < 4; i++) beat_data[i] = 128'(8'hA0 + i);
        axi_read(27'h100, 7, 1'b0, 2'b00, 2);
        beat_data[0] = 128'hDEAD_BEEF;
        axi_write(27'h300, 0, 16'hFFFF, 2'b00);
        axi_read(27'h300, 0, 1'b0, 2'b00, -1);

        // Burst crossing the top of the store wraps to word 0
        beat_data[0] = 128'hB0;
        beat_data[1] = 128'hB1;
        axi_write(27'(((1 << TB_ADDR_W) - 1) * 16), 1, 16'hFFFF, 2'b00);
        axi_read(27'(((1 << TB_ADDR_W) - 1) * 16), 1, 1'b0, 2'b00, -1);
        beat_data[0] = 128'hB1;
        axi_read(27'h0, 0, 1'b0, 2'b00, -1);

        // Start address just past the store: alias or SLVERR
        beat_data[0] = 128'hC0;
`ifdef AXI_DDR_SLAVE_RANGE_CHECK_EN
        axi_write(27'(1 << (TB_ADDR_W + 4)), 0, 16'hFFFF, 2'b10);
        beat_data[0] = 128'hB1;
        axi_read(27'h0, 0, 1'b0, 2'b00, -1);
        beat_data[0] = 128'd0;
        axi_read(27'(1 << (TB_ADDR_W + 4)), 0, 1'b0, 2'b10, -1);
`else
        axi_write(27'(1 << (TB_ADDR_W + 4)), 0, 16'hFFFF, 2'b00);
        axi_read(27'h0, 0, 1'b0, 2'b00, -1);
`endif

        // 256-beat burst
        for (int i = 0; i < 256; i++) beat_data[i] = {8'(i), 56'h0, 8'(~i), 56'h1234};
        axi_write(27'h1000, 255, 16'hFFFF, 2'b00);
        axi_read(27'h1000, 255, 1'b0, 2'b00, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
